// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: RAM BIST sequencer. It writes the pattern, reads it back ascending, writes the
// inverse, then reads it back descending. Define RAM_BIST_ERRCNT_EN to add the err_count output.
module ram_bist_ctrl #(
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
`ifdef RAM_BIST_ERRCNT_EN
  ,
  output logic [ADDR_WIDTH+1:0] err_count
`endif
);

  typedef enum logic [2:0] {IDLE, WR_PAT, RD_PAT, WR_INV, RD_INV, FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic                    drain;
  logic                    rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_d;
  logic [DATA_WIDTH-1:0]   exp_d;
  logic                    mismatch;

  // rd_data belongs to the read issued one cycle earlier, so compare against delayed copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_d   <= 1'b0;
      rd_addr_d <= '0;
      exp_d     <= '0;
    end else begin
      rd_en_d   <= rd_en;
      rd_addr_d <= rd_addr;
      exp_d     <= (state == RD_INV) ? ~PATTERN : PATTERN;
    end
  end

  always_comb begin
    mismatch = 1'b0;
    if (rd_en_d && (rd_data != exp_d)) mismatch = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
`ifdef RAM_BIST_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (mismatch) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= rd_addr_d;
          fail_data <= rd_data;
        end
`ifdef RAM_BIST_ERRCNT_EN
        if (err_count != '1) err_count <= err_count + 1'b1;
`endif
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef RAM_BIST_ERRCNT_EN
            err_count <= '0;
`endif
            state     <= WR_PAT;
            busy      <= 1'b1;
            wr_en     <= 1'b1;
            wr_addr   <= '0;
            wr_data   <= PATTERN;
          end
        end
        WR_PAT: begin
          if (wr_addr == LAST) begin
            state   <= RD_PAT;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        RD_PAT: begin
          if (drain) begin
            drain   <= 1'b0;
            state   <= WR_INV;
            wr_en   <= 1'b1;
            wr_addr <= '0;
            wr_data <= ~PATTERN;
          end else if (rd_addr == LAST) begin
            drain   <= 1'b1;
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        WR_INV: begin
          if (wr_addr == LAST) begin
            state   <= RD_INV;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            rd_en   <= 1'b1;
            rd_addr <= LAST;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        RD_INV: begin
          if (drain) begin
            drain <= 1'b0;
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !(fail || mismatch);
          end else if (rd_addr == '0) begin
            drain <= 1'b1;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr - 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

`ifndef RAM_BIST_ERRCNT_EN
      // A mismatch overrides whatever phase step was scheduled above and ends the test.
      if (mismatch && busy) begin
        state <= FINISH;
        drain <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b0;
        wr_en <= 1'b0;
        rd_en <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl: behavioural RAM with stuck-at faults, directed table plus random
// fault sets checked against a phase-order reference model.
module tb_ram_bist_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam logic [7:0]  PAT   = 8'h55;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, fail, wr_en, rd_en;
  logic [AW-1:0] fail_addr, wr_addr, rd_addr;
  logic [DW-1:0] fail_data, wr_data;
  logic [DW-1:0] rd_data = '0;

  ram_bist_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN(PAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= (mem[rd_addr] | sa1[rd_addr]) & ~sa0[rd_addr];
  end

  int both_cnt = 0;
  int wr_cnt = 0;
  logic [11:0] wr_log [$];
  logic [3:0]  rd_log [$];

  always @(negedge clk) begin
    if (wr_en && rd_en) both_cnt++;
    if (wr_en) begin
      wr_cnt++;
      wr_log.push_back({wr_addr, wr_data});
    end
    if (rd_en) rd_log.push_back(rd_addr);
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int         a0;
    logic [7:0] m1_0, m0_0;
    int         a1;
    logic [7:0] m1_1, m0_1;
    bit         retrig;
    bit         e_pass;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    int         e_busy;
  } vec_t;

  function automatic vec_t mk(input int a0, input logic [7:0] m1_0, input logic [7:0] m0_0,
                              input int a1, input logic [7:0] m1_1, input logic [7:0] m0_1,
                              input bit retrig, input bit e_pass, input logic [3:0] e_addr,
                              input logic [7:0] e_data, input int e_busy);
    vec_t v;
    v.a0 = a0; v.m1_0 = m1_0; v.m0_0 = m0_0;
    v.a1 = a1; v.m1_1 = m1_1; v.m0_1 = m0_1;
    v.retrig = retrig; v.e_pass = e_pass; v.e_addr = e_addr; v.e_data = e_data;
    v.e_busy = e_busy;
    return v;
  endfunction

  function automatic void set_faults(input vec_t v);
    for (int k = 0; k < DEPTH; k++) begin
      sa1[k] = '0;
      sa0[k] = '0;
    end
    if (v.a0 >= 0) begin sa1[v.a0] = v.m1_0; sa0[v.a0] = v.m0_0; end
    if (v.a1 >= 0) begin sa1[v.a1] = v.m1_1; sa0[v.a1] = v.m0_1; end
  endfunction

  // Reference: scan the two read phases in test order and stop at the first bad word. Reads
  // start after DEPTH writes (plus drain and DEPTH more writes for the inverse phase); the
  // compare cycle, one after the issue, is the last busy cycle.
  function automatic vec_t model(input vec_t v);
    vec_t       r;
    logic [7:0] val, inv;
    r = v;
    r.e_pass = 1'b1; r.e_addr = '0; r.e_data = '0; r.e_busy = 4 * DEPTH + 2;
    for (int k = 0; k < DEPTH; k++) begin
      val = (PAT | sa1[k]) & ~sa0[k];
      if (val != PAT) begin
        r.e_pass = 1'b0; r.e_addr = 4'(k); r.e_data = val; r.e_busy = DEPTH + k + 2;
        return r;
      end
    end
    inv = ~PAT;
    for (int k = 0; k < DEPTH; k++) begin
      val = (inv | sa1[DEPTH-1-k]) & ~sa0[DEPTH-1-k];
      if (val != inv) begin
        r.e_pass = 1'b0; r.e_addr = 4'(DEPTH - 1 - k); r.e_data = val;
        r.e_busy = 3 * DEPTH + 3 + k;
        return r;
      end
    end
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int         bcnt, cyc, dcyc, extra;
    bit         got;
    logic       p, f;
    logic [3:0] fa;
    logic [7:0] fd;
    set_faults(v);
    bcnt = 0; cyc = 0; dcyc = 0; extra = 0; got = 0;
    p = 0; f = 0; fa = '0; fd = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got && cyc < 400) begin
      cyc++;
      if (busy) bcnt++;
      if (done) begin
        got = 1; dcyc = cyc; p = pass; f = fail; fa = fail_addr; fd = fail_data;
      end else begin
        start = v.retrig && (cyc == 3 || cyc == 40);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(v.e_busy));
    check({tag, "_done_cycle"}, 32'(dcyc), 32'(v.e_busy + 1));
    check({tag, "_pass"}, 32'(p), 32'(v.e_pass));
    check({tag, "_fail"}, 32'(f), 32'(!v.e_pass));
    check({tag, "_fail_addr"}, 32'(fa), 32'(v.e_addr));
    check({tag, "_fail_data"}, 32'(fd), 32'(v.e_data));
    repeat (8) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check({tag, "_quiet_after_done"}, 32'(extra), 32'd0);
    check({tag, "_pass_held"}, 32'(pass), 32'(v.e_pass));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 32'({busy, done, pass, fail, wr_en, rd_en}), 32'd0);
    check({tag, "_addrs"}, 32'({fail_addr, wr_addr, rd_addr}), 32'd0);
    check({tag, "_data"}, 32'({fail_data, wr_data}), 32'd0);
  endtask

  vec_t tbl [8];
  vec_t clean;

  initial begin
    int   cyc, wr_before, nf;
    bit   got;
    vec_t v;

    tbl[0] = mk(-1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 0, 1, 4'd0,  8'h00, 66);
    tbl[1] = mk( 5, 8'h01, 8'h00, -1, 8'h00, 8'h00, 0, 0, 4'd5,  8'hAB, 61);
    tbl[2] = mk( 9, 8'h00, 8'h80, -1, 8'h00, 8'h00, 0, 0, 4'd9,  8'h2A, 57);
    tbl[3] = mk( 3, 8'h02, 8'h00, -1, 8'h00, 8'h00, 0, 0, 4'd3,  8'h57, 21);
    tbl[4] = mk(15, 8'h00, 8'h01, -1, 8'h00, 8'h00, 0, 0, 4'd15, 8'h54, 33);
    tbl[5] = mk( 0, 8'h01, 8'h00, -1, 8'h00, 8'h00, 0, 0, 4'd0,  8'hAB, 66);
    tbl[6] = mk(-1, 8'h00, 8'h00, -1, 8'h00, 8'h00, 1, 1, 4'd0,  8'h00, 66);
    tbl[7] = mk( 2, 8'h01, 8'h00, 11, 8'h01, 8'h00, 0, 0, 4'd11, 8'hAB, 55);
    clean  = tbl[0];
    set_faults(clean);

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Full write/read address and data order on a clean RAM.
    wr_log.delete();
    rd_log.delete();
    apply(clean, "seq");
    check("seq_wr_len", 32'(wr_log.size()), 32'(2 * DEPTH));
    check("seq_rd_len", 32'(rd_log.size()), 32'(2 * DEPTH));
    for (int k = 0; k < 2 * DEPTH && k < wr_log.size(); k++)
      check($sformatf("seq_wr%0d", k), 32'(wr_log[k]),
            32'({4'(k % DEPTH), (k < DEPTH) ? PAT : ~PAT}));
    for (int k = 0; k < 2 * DEPTH && k < rd_log.size(); k++)
      check($sformatf("seq_rd%0d", k), 32'(rd_log[k]),
            32'((k < DEPTH) ? k : (2 * DEPTH - 1 - k)));

    // start held high: FINISH ignores it, IDLE restarts on the following edge.
    set_faults(clean);
    start = 1'b1;
    @(negedge clk);
    cyc = 1; got = 0;
    while (!got && cyc < 400) begin
      if (done) got = 1;
      else begin cyc++; @(negedge clk); end
    end
    check("hold_done_seen", 32'(got), 32'd1);
    check("hold_done_cycle", 32'(cyc), 32'(4 * DEPTH + 3));
    @(negedge clk);
    check("hold_idle_gap", 32'({busy, wr_en}), 32'd0);
    @(negedge clk);
    check("hold_restart", 32'({busy, wr_en, wr_addr, wr_data}), 32'({2'b11, 4'd0, PAT}));
    start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    check("hold_second_done", 32'(got), 32'd1);
    check("hold_second_pass", 32'(pass), 32'd1);
    @(negedge clk);

    // Reset in the middle of a test.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    check("mid_busy_before_rst", 32'({busy, rd_en}), 32'd3);
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wr_before = wr_cnt;
    repeat (20) @(negedge clk);
    check("mid_no_writes_after_rst", 32'(wr_cnt - wr_before), 32'd0);
    check("mid_idle_after_rst", 32'({busy, done, pass, fail}), 32'd0);
    apply(clean, "post_rst");

    // Random fault sets against the reference model.
    for (int n = 0; n < 24; n++) begin
      v = clean;
      v.retrig = bit'($urandom_range(0, 1));
      nf = $urandom_range(0, 2);
      if (nf >= 1) begin
        v.a0 = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) != 0) v.m1_0 = 8'(1 << $urandom_range(0, 7));
        else                           v.m0_0 = 8'(1 << $urandom_range(0, 7));
      end
      if (nf == 2) begin
        v.a1 = $urandom_range(0, DEPTH - 1);
        if (v.a1 == v.a0) v.a1 = -1;
        else if ($urandom_range(0, 1) != 0) v.m1_1 = 8'(1 << $urandom_range(0, 7));
        else                                v.m0_1 = 8'(1 << $urandom_range(0, 7));
      end
      set_faults(v);
      v = model(v);
      apply(v, $sformatf("rnd%0d", n));
    end

    check("wr_rd_never_both", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
